// File: rtl/alarm_buzzer_ctrl_pkg.sv
// Shared definitions for the alarm buzzer block: state encoding, BCD time-word
// layout and the BCD validity check used to decide whether an alarm is set.
package alarm_pkg;

    // BCD time word layout {h_t, h_o, m_t, m_o, s_t, s_o}
    localparam int DIGIT_W    = 4;
    localparam int TIME_W     = 24;
    localparam int NUM_DIGITS = TIME_W / DIGIT_W;

    // LSB position of each digit inside the time word
    localparam int H_T_LSB = 20;
    localparam int H_O_LSB = 16;
    localparam int M_T_LSB = 12;
    localparam int M_O_LSB = 8;
    localparam int S_T_LSB = 4;
    localparam int S_O_LSB = 0;

    // FSM state encoding, also exported on the state port
    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] RINGING = 2'd2;
    localparam logic [1:0] SNOOZE  = 2'd3;

    // A word is valid BCD when every digit is 0..9; an unset alarm uses 4'hF digits
    function automatic logic bcd_valid(input logic [TIME_W-1:0] word);
        return (word[H_T_LSB +: DIGIT_W] <= 4'd9) &&
               (word[H_O_LSB +: DIGIT_W] <= 4'd9) &&
               (word[M_T_LSB +: DIGIT_W] <= 4'd9) &&
               (word[M_O_LSB +: DIGIT_W] <= 4'd9) &&
               (word[S_T_LSB +: DIGIT_W] <= 4'd9) &&
               (word[S_O_LSB +: DIGIT_W] <= 4'd9);
    endfunction

endpackage

// File: rtl/alarm_buzzer_ctrl_tone_gen.sv
// Buzzer tone and beep cadence generator. While en is high the tone toggles
// every TONE_DIV cycles and the cadence gate toggles every CADENCE_CYC cycles,
// starting in the ON phase. While en is low both counters are parked at zero,
// the tone is held low and the cadence is pre-loaded to ON so that every new
// ring period starts with an audible beep window.
module buzz_tone_gen #(
    parameter int TONE_DIV    = 12_500,
    parameter int CADENCE_CYC = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tone_out,
    output logic cadence_on
);

    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int CAD_W  = (CADENCE_CYC > 1) ? $clog2(CADENCE_CYC) : 1;

    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [CAD_W-1:0]  CAD_LAST  = CAD_W'(CADENCE_CYC - 1);

    logic [TONE_W-1:0] tone_cnt;
    logic [CAD_W-1:0]  cad_cnt;

    // Tone half-period counter; restarts from zero with the tone low on every enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            tone_out <= 1'b0;
        end else if (!en) begin
            tone_cnt <= '0;
            tone_out <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_out <= ~tone_out;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

    // Beep on/off cadence; parked in the ON phase while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cad_cnt    <= '0;
            cadence_on <= 1'b1;
        end else if (!en) begin
            cad_cnt    <= '0;
            cadence_on <= 1'b1;
        end else if (cad_cnt == CAD_LAST) begin
            cad_cnt    <= '0;
            cadence_on <= ~cadence_on;
        end else begin
            cad_cnt <= cad_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_buzzer_ctrl.sv
// Alarm buzzer controller. Compares the confirmed BCD alarm word against the
// running time, rings the buzzer once per matching second, and handles the
// stop key, the unanswered-ring timeout and (optionally) snooze.
// Optional feature macro: ALARM_SNOOZE_EN. When it is not defined the SNOOZE
// state and its counters are not built and snooze_key behaves as stop_key.
module alarm_buzzer_ctrl
    import alarm_pkg::*;
#(
    parameter int TONE_DIV    = 12_500,
    parameter int CADENCE_CYC = 12_500_000,
    parameter int RING_SEC    = 60,
    parameter int SNOOZE_SEC  = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic [TIME_W-1:0] time_bcd,
    input  logic [TIME_W-1:0] alarm_bcd,
    input  logic              alarm_ready,
    input  logic              stop_key,
    input  logic              snooze_key,
    output logic              buzzer,
    output logic              ringing,
    output logic [1:0]        state
);

    localparam int RING_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);

    logic              alarm_valid;
    logic              match;
    logic              match_q;
    logic              hit;
    state_t            state_q;
    state_t            state_next;
    logic [RING_W-1:0] ring_sec_q;
    logic [RING_W-1:0] ring_sec_next;
    logic              ring_done;
    logic              tone;
    logic              cadence_on;
    logic              buzzer_q;

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_W = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam int CNT_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'(SNOOZE_SEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SNOOZE);

    logic [SNZ_W-1:0] snz_sec_q;
    logic [SNZ_W-1:0] snz_sec_next;
    logic [CNT_W-1:0] snooze_cnt_q;
    logic [CNT_W-1:0] snooze_cnt_next;
    logic             snz_done;
`endif

    // An alarm only counts once the setting stage confirms it and it is real BCD;
    // ringing is triggered by the rising edge of the match so one second rings once
    assign alarm_valid = alarm_ready & bcd_valid(alarm_bcd);
    assign match       = alarm_valid & (time_bcd == alarm_bcd);
    assign hit         = match & ~match_q;
    assign ring_done   = tick_1hz & (ring_sec_q == RING_LAST);

`ifdef ALARM_SNOOZE_EN
    assign snz_done = tick_1hz & (snz_sec_q == SNZ_LAST);
`endif

    // Next-state and second-counter logic; losing a valid alarm overrides everything,
    // then stop beats timeout, timeout beats snooze, and snooze beats a new hit
    always_comb begin
        state_next    = state_q;
        ring_sec_next = ring_sec_q;
`ifdef ALARM_SNOOZE_EN
        snz_sec_next    = snz_sec_q;
        snooze_cnt_next = snooze_cnt_q;
`endif
        if (!alarm_valid) begin
            state_next    = IDLE;
            ring_sec_next = '0;
`ifdef ALARM_SNOOZE_EN
            snz_sec_next    = '0;
            snooze_cnt_next = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_next = ARMED;
                end
                ARMED: begin
                    if (hit) begin
                        state_next    = RINGING;
                        ring_sec_next = '0;
                    end
                end
                RINGING: begin
                    if (stop_key || ring_done) begin
                        state_next    = ARMED;
                        ring_sec_next = '0;
`ifdef ALARM_SNOOZE_EN
                        snooze_cnt_next = '0;
`endif
                    end else if (snooze_key) begin
`ifdef ALARM_SNOOZE_EN
                        if (snooze_cnt_q < CNT_MAX) begin
                            state_next      = SNOOZE;
                            ring_sec_next   = '0;
                            snz_sec_next    = '0;
                            snooze_cnt_next = snooze_cnt_q + 1'b1;
                        end else begin
                            state_next      = ARMED;
                            ring_sec_next   = '0;
                            snooze_cnt_next = '0;
                        end
`else
                        state_next    = ARMED;
                        ring_sec_next = '0;
`endif
                    end else if (tick_1hz) begin
                        ring_sec_next = ring_sec_q + 1'b1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (stop_key) begin
                        state_next      = ARMED;
                        snz_sec_next    = '0;
                        snooze_cnt_next = '0;
                    end else if (snz_done) begin
                        state_next    = RINGING;
                        ring_sec_next = '0;
                        snz_sec_next  = '0;
                    end else if (tick_1hz) begin
                        snz_sec_next = snz_sec_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, second counters and the match history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ring_sec_q <= '0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_next;
            ring_sec_q <= ring_sec_next;
            match_q    <= match;
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Snooze duration counter and the per-event snooze tally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snz_sec_q    <= '0;
            snooze_cnt_q <= '0;
        end else begin
            snz_sec_q    <= snz_sec_next;
            snooze_cnt_q <= snooze_cnt_next;
        end
    end
`endif

    buzz_tone_gen #(
        .TONE_DIV    (TONE_DIV),
        .CADENCE_CYC (CADENCE_CYC)
    ) u_tone_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_q == RINGING),
        .tone_out   (tone),
        .cadence_on (cadence_on)
    );

    // Buzzer drive is gated with the next state so it drops in the very cycle
    // the FSM leaves RINGING instead of lingering one cycle behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzzer_q <= 1'b0;
        end else begin
            buzzer_q <= tone & cadence_on & (state_next == RINGING);
        end
    end

    assign buzzer  = buzzer_q;
    assign ringing = (state_q == RINGING);
    assign state   = state_q;

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Self-checking bench for alarm_buzzer_ctrl: a vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
// Honors ALARM_SNOOZE_EN the same way the design does.
module tb_alarm_buzzer_ctrl;

    localparam int TONE_DIV    = 4;
    localparam int CADENCE_CYC = 16;
    localparam int RING_SEC    = 5;
    localparam int SNOOZE_SEC  = 3;
    localparam int MAX_SNOOZE  = 2;

`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_1hz;
    logic [23:0] time_bcd;
    logic [23:0] alarm_bcd;
    logic        alarm_ready;
    logic        stop_key;
    logic        snooze_key;
    logic        buzzer;
    logic        ringing;
    logic [1:0]  state;

    int n_compared = 0;
    int n_failed   = 0;

    // Behavioural model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing
    int m_mode;
    bit m_prev_match;
    int m_rung_secs;
    int m_snz_secs;
    int m_snoozes;
    int m_age;
    bit m_buzz;

    typedef struct {
        bit          tick;
        logic [23:0] tm;
        logic [23:0] al;
        bit          rdy;
        bit          stop;
        bit          snz;
        int          exp_state;
        bit          exp_ringing;
        bit          exp_buzzer;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    alarm_buzzer_ctrl #(
        .TONE_DIV    (TONE_DIV),
        .CADENCE_CYC (CADENCE_CYC),
        .RING_SEC    (RING_SEC),
        .SNOOZE_SEC  (SNOOZE_SEC),
        .MAX_SNOOZE  (MAX_SNOOZE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .time_bcd    (time_bcd),
        .alarm_bcd   (alarm_bcd),
        .alarm_ready (alarm_ready),
        .stop_key    (stop_key),
        .snooze_key  (snooze_key),
        .buzzer      (buzzer),
        .ringing     (ringing),
        .state       (state)
    );

    function automatic bit digits_ok(input logic [23:0] w);
        bit ok = 1'b1;
        for (int d = 0; d < 6; d++) begin
            if (((w >> (4 * d)) & 24'hF) > 9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic model_reset();
        m_mode       = 0;
        m_prev_match = 1'b0;
        m_rung_secs  = 0;
        m_snz_secs   = 0;
        m_snoozes    = 0;
        m_age        = 0;
        m_buzz       = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_cycle();
        bit valid;
        bit matched;
        bit hit;
        int prev;
        valid        = alarm_ready && digits_ok(alarm_bcd);
        matched      = valid && (time_bcd == alarm_bcd);
        hit          = matched && !m_prev_match;
        m_prev_match = matched;
        prev         = m_mode;
        if (!valid) begin
            m_mode      = 0;
            m_rung_secs = 0;
            m_snz_secs  = 0;
            m_snoozes   = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (hit) begin
                m_mode      = 2;
                m_rung_secs = 0;
            end
        end else if (m_mode == 2) begin
            if (stop_key || (snooze_key && !SNZ_EN)) begin
                m_mode    = 1;
                m_snoozes = 0;
            end else if (tick_1hz && (m_rung_secs + 1 == RING_SEC)) begin
                m_mode    = 1;
                m_snoozes = 0;
            end else if (snooze_key) begin
                if (m_snoozes < MAX_SNOOZE) begin
                    m_mode     = 3;
                    m_snoozes  = m_snoozes + 1;
                    m_snz_secs = 0;
                end else begin
                    m_mode    = 1;
                    m_snoozes = 0;
                end
            end else if (tick_1hz) begin
                m_rung_secs = m_rung_secs + 1;
            end
        end else begin
            if (stop_key) begin
                m_mode    = 1;
                m_snoozes = 0;
            end else if (tick_1hz) begin
                m_snz_secs = m_snz_secs + 1;
                if (m_snz_secs == SNOOZE_SEC) begin
                    m_mode      = 2;
                    m_rung_secs = 0;
                    m_snz_secs  = 0;
                end
            end
        end
        // Buzzer follows the tone/cadence of the previous cycle of this ring period
        if (m_mode == 2) m_age = (prev == 2) ? m_age + 1 : 0;
        else             m_age = 0;
        m_buzz = (m_mode == 2) && (m_age >= 1) &&
                 (((m_age - 1) / TONE_DIV) % 2 == 1) &&
                 (((m_age - 1) / CADENCE_CYC) % 2 == 0);
    endtask

    // Drive one clock of stimulus; time, alarm and ready hold their current values
    task automatic apply_stimulus(input bit tk, input bit st, input bit sn);
        tick_1hz   = tk;
        stop_key   = st;
        snooze_key = sn;
        model_cycle();
        @(posedge clk);
        #1;
        tick_1hz   = 1'b0;
        stop_key   = 1'b0;
        snooze_key = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_output({tag, "_state"}, 32'(state), 32'(m_mode));
        check_output({tag, "_ringing"}, 32'(ringing), 32'(m_mode == 2));
        check_output({tag, "_buzzer"}, 32'(buzzer), 32'(m_buzz));
    endtask

    // From ARMED with alarm 07:30:00: leave the match second and come back to it
    task automatic ring_up(input string tag);
        time_bcd = 24'h073001;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        time_bcd = 24'h073000;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output({tag, "_ring_up"}, 32'(state), 32'd2);
    endtask

    initial begin
        logic [23:0] pool[4];
        int highs;

        vecs[0]  = '{1, 24'h072959, 24'hFFFFFF, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 24'h235959, 24'hFFFFFF, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 24'h000000, 24'hFFFFFF, 1, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 24'h072958, 24'h073000, 1, 0, 0, 1, 0, 0};
        vecs[4]  = '{1, 24'h072959, 24'h073000, 1, 0, 0, 1, 0, 0};
        vecs[5]  = '{1, 24'h073000, 24'h073000, 1, 0, 0, 2, 1, 0};
        vecs[6]  = '{0, 24'h073000, 24'h073000, 1, 0, 0, 2, 1, 0};
        vecs[7]  = '{0, 24'h073000, 24'h073000, 1, 1, 0, 1, 0, 0};
        vecs[8]  = '{1, 24'h073000, 24'h073000, 1, 0, 0, 1, 0, 0};
        vecs[9]  = '{1, 24'h073001, 24'h073000, 1, 0, 0, 1, 0, 0};
        vecs[10] = '{1, 24'h073000, 24'h073000, 1, 0, 0, 2, 1, 0};
        vecs[11] = '{0, 24'h073000, 24'h073000, 1, 1, 1, 1, 0, 0};

        rst_n       = 1'b0;
        tick_1hz    = 1'b0;
        time_bcd    = 24'h000000;
        alarm_bcd   = 24'hFFFFFF;
        alarm_ready = 1'b0;
        stop_key    = 1'b0;
        snooze_key  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_state", 32'(state), 32'd0);
        check_output("reset_ringing", 32'(ringing), 32'd0);
        check_output("reset_buzzer", 32'(buzzer), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            time_bcd    = vecs[i].tm;
            alarm_bcd   = vecs[i].al;
            alarm_ready = vecs[i].rdy;
            apply_stimulus(vecs[i].tick, vecs[i].stop, vecs[i].snz);
            check_output($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            check_output($sformatf("vec%0d_ringing", i), 32'(ringing), 32'(vecs[i].exp_ringing));
            check_output($sformatf("vec%0d_buzzer", i), 32'(buzzer), 32'(vecs[i].exp_buzzer));
            check_model($sformatf("vec%0d_model", i));
        end

        $display("[TB] buzzer pattern");
        ring_up("pattern");
        highs = 0;
        for (int k = 1; k <= 40; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0);
            check_model($sformatf("pattern%0d", k));
            if (buzzer === 1'b1) highs++;
        end
        check_output("pattern_highs", 32'(highs), 32'd12);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("pattern_stop_state", 32'(state), 32'd1);
        check_output("pattern_stop_buzzer", 32'(buzzer), 32'd0);

        $display("[TB] ring timeout");
        ring_up("timeout");
        for (int t = 1; t <= 4; t++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            check_output($sformatf("timeout_tick%0d", t), 32'(state), 32'd2);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("timeout_state", 32'(state), 32'd1);
        check_output("timeout_buzzer", 32'(buzzer), 32'd0);
        for (int t = 0; t < 2; t++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            check_output($sformatf("timeout_no_rering%0d", t), 32'(state), 32'd1);
        end

        $display("[TB] snooze");
        ring_up("snooze");
`ifdef ALARM_SNOOZE_EN
        for (int s = 0; s < 2; s++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1);
            check_output($sformatf("snooze%0d_enter", s), 32'(state), 32'd3);
            check_model($sformatf("snooze%0d", s));
            apply_stimulus(1'b1, 1'b0, 1'b0);
            apply_stimulus(1'b1, 1'b0, 1'b0);
            check_output($sformatf("snooze%0d_wait", s), 32'(state), 32'd3);
            apply_stimulus(1'b1, 1'b0, 1'b0);
            check_output($sformatf("snooze%0d_rering", s), 32'(state), 32'd2);
        end
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("snooze_limit_state", 32'(state), 32'd1);
        check_model("snooze_limit");

        ring_up("clear");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_output("both_keys_state", 32'(state), 32'd1);
        ring_up("clear2");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("snooze_cnt_cleared", 32'(state), 32'd3);
        check_model("clear2");
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("snooze_stop_state", 32'(state), 32'd1);
`else
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("snooze_as_stop_state", 32'(state), 32'd1);
        check_output("snooze_as_stop_buzzer", 32'(buzzer), 32'd0);
`endif

        $display("[TB] alarm_ready drop");
        ring_up("drop");
        repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0);
        alarm_ready = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("drop_state", 32'(state), 32'd0);
        check_output("drop_buzzer", 32'(buzzer), 32'd0);
        check_output("drop_ringing", 32'(ringing), 32'd0);
        alarm_ready = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("restore_state", 32'(state), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_model("restore");

        $display("[TB] reset mid-ring");
        ring_up("rst");
        repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("pre_reset_buzzer", 32'(buzzer), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_state", 32'(state), 32'd0);
        check_output("async_reset_ringing", 32'(ringing), 32'd0);
        check_output("async_reset_buzzer", 32'(buzzer), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_model("post_reset");

        $display("[TB] midnight");
        alarm_bcd = 24'h000000;
        time_bcd  = 24'h235959;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("midnight_armed", 32'(state), 32'd1);
        time_bcd = 24'h000000;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("midnight_state", 32'(state), 32'd2);
        check_output("midnight_ringing", 32'(ringing), 32'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_model("midnight_stop");

        $display("[TB] randomized run");
        alarm_bcd = 24'h123456;
        pool[0]   = 24'h123456;
        pool[1]   = 24'h123455;
        pool[2]   = 24'h000000;
        pool[3]   = 24'h235959;
        for (int n = 0; n < 3000; n++) begin
            bit tk;
            tk = ($urandom_range(0, 5) == 0);
            if (tk) time_bcd = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 299) == 0) alarm_ready = ~alarm_ready;
            if (!alarm_ready && $urandom_range(0, 9) == 0) alarm_ready = 1'b1;
            if ($urandom_range(0, 499) == 0)
                alarm_bcd = (alarm_bcd == 24'h123456) ? 24'h12A456 : 24'h123456;
            apply_stimulus(tk, $urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0);
            check_model($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
